// File: rtl/countdown_pkg.sv
// Shared types, glyph table and BCD helpers for the countdown game controller.
package countdown_pkg;

   typedef enum logic [1:0] {STARTUP, RUN, WIN, LOSE} state_e;

   // Active-low segment patterns, bit 6 = g ... bit 0 = a.
   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_C     = 7'b1000110;
   localparam logic [6:0] GLYPH_L     = 7'b1000111;
   localparam logic [6:0] GLYPH_U     = 7'b1000001;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = GLYPH_0;
         4'd1:    seg = GLYPH_1;
         4'd2:    seg = GLYPH_2;
         4'd3:    seg = GLYPH_3;
         4'd4:    seg = GLYPH_4;
         4'd5:    seg = GLYPH_5;
         4'd6:    seg = GLYPH_6;
         4'd7:    seg = GLYPH_7;
         4'd8:    seg = GLYPH_8;
         4'd9:    seg = GLYPH_9;
         default: seg = GLYPH_BLANK;
      endcase
      return seg;
   endfunction

   // Elaboration-time only: turns the start value into packed BCD (up to 8 digits).
   function automatic logic [31:0] to_bcd(input int unsigned value);
      logic [31:0] res;
      int unsigned v;
      res = '0;
      v   = value;
      for (int i = 0; i < 8; i++) begin
         res[i*4 +: 4] = 4'(v % 10);
         v             = v / 10;
      end
      return res;
   endfunction

endpackage

// File: rtl/countdown_game_ctrl_if.sv
// Board-side signal bundle of the countdown game controller.
// master = board/test side, slave = controller.
interface countdown_game_ctrl_if #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned SW_WIDTH  = 8,
   parameter int unsigned LED_WIDTH = 8
);
   logic                 start;
   logic                 stop;
   logic                 multiply;
   logic [SW_WIDTH-1:0]  sw;
   logic [LED_WIDTH-1:0] Led;
   logic [6:0]           seg;
   logic [DIGITS-1:0]    an;
   logic                 dp;
   logic                 win;
   logic                 lose;

   modport master (
      output start, stop, multiply, sw,
      input  Led, seg, an, dp, win, lose
   );

   modport slave (
      input  start, stop, multiply, sw,
      output Led, seg, an, dp, win, lose
   );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed active-low seven-segment scanner: steps one digit every SCAN_DIV
// clocks and registers the anode, segment and decimal-point outputs.
module seven_seg_scan #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 131072
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DIGITS-1:0][6:0] glyphs_i,
   input  logic [DIGITS-1:0]      dp_n_i,
   output logic [6:0]             seg_o,
   output logic [DIGITS-1:0]      an_o,
   output logic                   dp_o
);

   localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              dp_q, dp_d;
   logic              scan_wrap;

   // Divider, digit index and the outputs for the digit currently selected.
   always_comb begin
      scan_wrap  = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
      idx_d      = idx_q;
      if (scan_wrap) begin
         idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = glyphs_i[idx_q];
      dp_d  = dp_n_i[idx_q];
   end

   // Scan state and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_q      <= 7'b1111111;
         an_q       <= '1;
         dp_q       <= 1'b1;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         dp_q       <= dp_d;
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;
   assign dp_o  = dp_q;

endmodule

// File: rtl/countdown_game_ctrl.sv
// Countdown game controller: N-digit decimal countdown, popcount guess with
// optional doubling, win/lose detection and a multiplexed 7-segment display.
// Optional macro COUNTDOWN_DP_BLINK_EN: blinks the digit-0 decimal point in RUN
// for the first half of every tick period.
module countdown_game_ctrl
   import countdown_pkg::*;
#(
   parameter int unsigned CLOCK       = 50000000,
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned SW_WIDTH    = 8,
   parameter int unsigned LED_WIDTH   = 8,
   parameter int unsigned START_VALUE = 10,
   parameter int unsigned TICK_DIV    = CLOCK,
   parameter int unsigned SCAN_DIV    = 131072
) (
   input logic                  clk,
   input logic                  reset,
   countdown_game_ctrl_if.slave bus
);

   localparam int unsigned CntW  = $clog2(10 ** DIGITS);
   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [CntW-1:0]     StartCnt    = CntW'(START_VALUE);
   localparam logic [31:0]         StartBcdAll = to_bcd(START_VALUE);
   localparam logic [DIGITS*4-1:0] StartBcd    = StartBcdAll[DIGITS*4-1:0];

   state_e                   state_q, state_d;
   logic [CntW-1:0]          count_q, count_d;
   logic [DIGITS-1:0][3:0]   bcd_q, bcd_d, bcd_dec;
   logic [TickW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [LED_WIDTH-1:0]     led_q, led_d;
   logic                     win_q, win_d;
   logic                     lose_q, lose_d;
   logic                     tick;
   logic                     dec_borrow;
   logic                     lead_zero;
   logic [DIGITS-1:0][6:0]   glyphs;
   logic [DIGITS-1:0]        dp_n;

   // Guess = popcount of the switches, doubled when multiply is held.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
         led_d = led_d + LED_WIDTH'(bus.sw[i]);
      end
      if (bus.multiply) begin
         led_d = led_d << 1;
      end
   end

   // Tick divider only counts in RUN; holding it at 0 elsewhere clears it on entry.
   always_comb begin
      tick       = (state_q == RUN) && (tick_cnt_q == TickW'(TICK_DIV - 1));
      tick_cnt_d = '0;
      if (state_q == RUN) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
      end
   end

   // BCD count minus one via a ripple borrow, kept in step with the binary count.
   always_comb begin
      bcd_dec    = bcd_q;
      dec_borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (dec_borrow) begin
            if (bcd_q[i] == 4'd0) begin
               bcd_dec[i] = 4'd9;
            end else begin
               bcd_dec[i] = bcd_q[i] - 4'd1;
               dec_borrow = 1'b0;
            end
         end
      end
   end

   // Game state machine next state; stop outranks a same-cycle tick.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      bcd_d   = bcd_q;
      unique case (state_q)
         STARTUP, WIN, LOSE: begin
            if (bus.start) begin
               state_d = RUN;
               count_d = StartCnt;
               bcd_d   = StartBcd;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = (32'(count_q) == 32'(led_q)) ? WIN : LOSE;
            end else if (tick && (count_q != '0)) begin
               count_d = count_q - CntW'(1);
               bcd_d   = bcd_dec;
               if (count_q == CntW'(1)) begin
                  state_d = LOSE;
               end
            end
         end
         default: state_d = STARTUP;
      endcase
      win_d  = (state_d == WIN);
      lose_d = (state_d == LOSE);
   end

   // Per-digit glyphs for the scanner; leading zeros blank except digit 0.
   always_comb begin
      glyphs    = {DIGITS{GLYPH_BLANK}};
      lead_zero = 1'b1;
      unique case (state_q)
         STARTUP: begin
            glyphs[0] = GLYPH_0;
            glyphs[1] = GLYPH_L;
            glyphs[2] = GLYPH_C;
         end
         RUN: begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
               if ((bcd_q[i] != 4'd0) || (i == 0)) begin
                  lead_zero = 1'b0;
               end
               glyphs[i] = lead_zero ? GLYPH_BLANK : bcd_to_seg(bcd_q[i]);
            end
         end
         WIN: begin
            for (int i = 0; i < DIGITS; i++) begin
               glyphs[i] = GLYPH_U;
            end
         end
         LOSE: begin
            for (int i = 0; i < DIGITS; i++) begin
               glyphs[i] = GLYPH_L;
            end
         end
         default: glyphs = {DIGITS{GLYPH_BLANK}};
      endcase
   end

`ifdef COUNTDOWN_DP_BLINK_EN
   // Digit-0 point lit (low) during the first half of each tick period in RUN.
   always_comb begin
      dp_n    = '1;
      dp_n[0] = !((state_q == RUN) && (tick_cnt_q < TickW'(TICK_DIV / 2)));
   end
`else
   // Decimal points stay dark.
   always_comb begin
      dp_n = '1;
   end
`endif

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= STARTUP;
         count_q    <= StartCnt;
         bcd_q      <= StartBcd;
         tick_cnt_q <= '0;
         led_q      <= '0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         bcd_q      <= bcd_d;
         tick_cnt_q <= tick_cnt_d;
         led_q      <= led_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
      end
   end

   assign bus.Led  = led_q;
   assign bus.win  = win_q;
   assign bus.lose = lose_q;

   seven_seg_scan #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk      (clk),
      .reset    (reset),
      .glyphs_i (glyphs),
      .dp_n_i   (dp_n),
      .seg_o    (bus.seg),
      .an_o     (bus.an),
      .dp_o     (bus.dp)
   );

endmodule
